// File: rtl/timer_defs.sv
// rtl/timer_defs.sv - shared BCD timer constants and digit type
package timer_defs;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Largest legal BCD digit; also the value a units digit takes on borrow.
    localparam bcd_t BCD_MAX = 4'd9;

    // Value the seconds-tens digit takes when a borrow comes out of the minutes.
    localparam bcd_t SEC_TENS_ROLL = 4'd5;

endpackage

// File: rtl/bcd_dec_digit.sv
// rtl/bcd_dec_digit.sv - one BCD decade cell of the countdown borrow chain
//
// Ports:
//   value_i      current digit
//   dec_en_i     decrement this digit (borrow in from the lower decade)
//   roll_val_i   value taken when the digit is 0 and must borrow
//   next_o       digit after the optional decrement
//   borrow_o     1 when this digit was 0 and borrowed from the next decade
module bcd_dec_digit
    import timer_defs::*;
(
    input  bcd_t value_i,
    input  logic dec_en_i,
    input  bcd_t roll_val_i,
    output bcd_t next_o,
    output logic borrow_o
);

    always_comb begin
        next_o   = value_i;
        borrow_o = 1'b0;
        if (dec_en_i) begin
            if (value_i != '0) begin
                next_o = value_i - bcd_t'(1);
            end else begin
                next_o   = roll_val_i;
                borrow_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_contagem.sv
// rtl/timer_contagem.sv - MM:SS countdown core with keypad shift-in and zero flag
//
// Ports:
//   clk100     system clock, rising edge
//   clearn     synchronous active-low reset
//   D          BCD digit from the keypad encoder
//   loadn      low while a key is held
//   pgt_1Hz    1 Hz tick, rising edge counts
//   enablen    0 = running (count), 1 = stopped (load)
//   mins       minutes digit
//   sec_tens   seconds tens digit
//   sec_ones   seconds units digit
//   zero       registered flag, 1 when all digits are 0
module timer_contagem
    import timer_defs::*;
#(
    parameter bcd_t SEC_TENS_ROLL = timer_defs::SEC_TENS_ROLL,
    parameter bcd_t BCD_MAX       = timer_defs::BCD_MAX
) (
    input  logic clk100,
    input  logic clearn,
    input  bcd_t D,
    input  logic loadn,
    input  logic pgt_1Hz,
    input  logic enablen,
    output bcd_t mins,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output logic zero
);

    logic loadn_q;
    logic tick_q;
    bcd_t mins_q, tens_q, ones_q;
    bcd_t mins_d, tens_d, ones_d;
    logic zero_q, zero_d;

    logic load_ev, tick_ev;
    logic do_load, do_count;

    bcd_t ones_dec, tens_dec, mins_dec;
    logic ones_borrow, tens_borrow, mins_borrow;

    assign load_ev = loadn_q & ~loadn;
    assign tick_ev = pgt_1Hz & ~tick_q;

    // enablen picks exactly one of load or count, so they can never collide.
    assign do_load  = enablen & load_ev & (D <= BCD_MAX);
    assign do_count = ~enablen & tick_ev & ~zero_q;

    bcd_dec_digit u_ones (
        .value_i    (ones_q),
        .dec_en_i   (do_count),
        .roll_val_i (BCD_MAX),
        .next_o     (ones_dec),
        .borrow_o   (ones_borrow)
    );

    bcd_dec_digit u_tens (
        .value_i    (tens_q),
        .dec_en_i   (ones_borrow),
        .roll_val_i (SEC_TENS_ROLL),
        .next_o     (tens_dec),
        .borrow_o   (tens_borrow)
    );

    bcd_dec_digit u_mins (
        .value_i    (mins_q),
        .dec_en_i   (tens_borrow),
        .roll_val_i (BCD_MAX),
        .next_o     (mins_dec),
        .borrow_o   (mins_borrow)
    );

    always_comb begin
        mins_d = mins_q;
        tens_d = tens_q;
        ones_d = ones_q;
        if (do_load) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = D;
        end else if (do_count && !mins_borrow) begin
            // A borrow out of the minutes would mean wrapping past 0:00;
            // zero_q already blocks that, the extra guard keeps 0:00 sticky.
            mins_d = mins_dec;
            tens_d = tens_dec;
            ones_d = ones_dec;
        end
        zero_d = (mins_d == '0) && (tens_d == '0) && (ones_d == '0);
    end

    always_ff @(posedge clk100) begin
        if (!clearn) begin
            mins_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            zero_q  <= 1'b1;
            // A key held through reset has to be released before it loads.
            loadn_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            mins_q  <= mins_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            zero_q  <= zero_d;
            loadn_q <= loadn;
            tick_q  <= pgt_1Hz;
        end
    end

    assign mins     = mins_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign zero     = zero_q;

endmodule
